// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Holds in-flight branch predictions in order and resolves them against the
// outcome from execute. For each resolve it emits a predictor training update.
// On a mispredict it also emits a one-cycle flush pulse with the corrected
// fetch PC. A mispredict empties the queue, because every younger entry was
// fetched down the wrong path.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_pred_*                prediction push from fetch (pc, taken, target)
//   o_pred_ready            queue not full
//   i_res_*                 resolve of the oldest entry from execute
//   o_res_ready             queue not empty
//   o_upd_valid/pc/taken    registered training update, one per resolve
//   o_mispredict            registered one-cycle flush pulse
//   o_redirect_pc           corrected fetch PC, valid with o_mispredict
//   o_count                 queue occupancy (0..DEPTH)
//   o_branch_cnt            saturating count of resolved branches
//   o_mispred_cnt           saturating count of mispredicts
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pred_valid,
  input  logic [PC_W-1:0]            i_pred_pc,
  input  logic                       i_pred_taken,
  input  logic [PC_W-1:0]            i_pred_target,
  output logic                       o_pred_ready,
  input  logic                       i_res_valid,
  input  logic                       i_res_taken,
  input  logic [PC_W-1:0]            i_res_target,
  output logic                       o_res_ready,
  output logic                       o_upd_valid,
  output logic [PC_W-1:0]            o_upd_pc,
  output logic                       o_upd_taken,
  output logic                       o_mispredict,
  output logic [PC_W-1:0]            o_redirect_pc,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [CNT_W-1:0]           o_branch_cnt,
  output logic [CNT_W-1:0]           o_mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [PC_W-1:0]  pc_mem_d  [DEPTH];
  logic [PC_W-1:0]  tgt_mem_q [DEPTH];
  logic [PC_W-1:0]  tgt_mem_d [DEPTH];
  logic [DEPTH-1:0] tkn_mem_q, tkn_mem_d;

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]  upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             push, resolve, mispredict;
  logic [PC_W-1:0]  head_pc, head_target;
  logic             head_taken;

  assign o_pred_ready = (count_q != CW'(DEPTH));
  assign o_res_ready  = (count_q != '0);

  assign push    = i_pred_valid && o_pred_ready;
  assign resolve = i_res_valid && o_res_ready;

  assign head_pc     = pc_mem_q[head_q];
  assign head_target = tgt_mem_q[head_q];
  assign head_taken  = tkn_mem_q[head_q];

  // A not-taken branch only mispredicts on direction; the target matters only when taken.
  assign mispredict = resolve &&
                      ((i_res_taken != head_taken) ||
                       (i_res_taken && (i_res_target != head_target)));

  always_comb begin
    pc_mem_d      = pc_mem_q;
    tgt_mem_d     = tgt_mem_q;
    tkn_mem_d     = tkn_mem_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    upd_valid_d   = resolve;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    mispredict_d  = mispredict;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (mispredict) begin
      // Flush: any push in this same cycle is on the wrong path and is dropped.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]  = i_pred_pc;
        tgt_mem_d[tail_q] = i_pred_target;
        tkn_mem_d[tail_q] = i_pred_taken;
        tail_d            = tail_q + AW'(1);
      end
      if (resolve) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(resolve);
    end

    if (resolve) begin
      upd_pc_d    = head_pc;
      upd_taken_d = i_res_taken;
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
    end

    if (mispredict) begin
      redirect_pc_d = i_res_taken ? i_res_target : head_pc + PC_W'(4);
      if (mispred_cnt_q != '1) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry payload needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    pc_mem_q  <= pc_mem_d;
    tgt_mem_q <= tgt_mem_d;
    tkn_mem_q <= tkn_mem_d;
  end

  assign o_upd_valid   = upd_valid_q;
  assign o_upd_pc      = upd_pc_q;
  assign o_upd_taken   = upd_taken_q;
  assign o_mispredict  = mispredict_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_count       = count_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver. The DUT is built with DEPTH=4 and CNT_W=4 so that
// both statistics counters can be driven into saturation quickly.
// The reference model is an ordered queue of predictions plus integer counters.
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_pred_valid;
  logic [PC_W-1:0]   i_pred_pc;
  logic              i_pred_taken;
  logic [PC_W-1:0]   i_pred_target;
  logic              o_pred_ready;
  logic              i_res_valid;
  logic              i_res_taken;
  logic [PC_W-1:0]   i_res_target;
  logic              o_res_ready;
  logic              o_upd_valid;
  logic [PC_W-1:0]   o_upd_pc;
  logic              o_upd_taken;
  logic              o_mispredict;
  logic [PC_W-1:0]   o_redirect_pc;
  logic [$clog2(DEPTH):0] o_count;
  logic [CNT_W-1:0]  o_branch_cnt;
  logic [CNT_W-1:0]  o_mispred_cnt;

  branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc),
    .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
    .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken),
    .i_res_target(i_res_target), .o_res_ready(o_res_ready),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_taken(o_upd_taken),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_count(o_count), .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  logic        e_upd_valid, e_upd_taken, e_mis;
  logic [31:0] e_upd_pc, e_redirect;
  int          e_bcnt, e_mcnt;
  int          checks = 0;
  int          errors = 0;
  bit          primed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptg, input logic rv, input logic rt,
                       input logic [31:0] rtg);
    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_target = ptg;
    i_res_valid = rv; i_res_taken = rt; i_res_target = rtg;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  // Advance one clock: predict from the queue state and current inputs, then
  // compare every registered output after the edge.
  task automatic step();
    ent_t h;
    bit   do_res, do_push, mis;
    ent_t n;
    if (primed) begin
      chk("pred_ready", {31'b0, o_pred_ready}, {31'b0, m_q.size() != DEPTH});
      chk("res_ready",  {31'b0, o_res_ready},  {31'b0, m_q.size() != 0});
    end
    if (i_rst) begin
      m_q.delete();
      e_upd_valid = 0; e_upd_taken = 0; e_mis = 0;
      e_upd_pc = 0; e_redirect = 0; e_bcnt = 0; e_mcnt = 0;
    end else begin
      do_res  = i_res_valid && (m_q.size() > 0);
      do_push = i_pred_valid && (m_q.size() < DEPTH);
      mis = 0;
      e_upd_valid = do_res;
      if (do_res) begin
        h = m_q.pop_front();
        if (i_res_taken) mis = (h.taken == 0) || (h.tgt != i_res_target);
        else             mis = (h.taken == 1);
        e_upd_pc    = h.pc;
        e_upd_taken = i_res_taken;
        e_bcnt      = (e_bcnt >= MAXC) ? MAXC : e_bcnt + 1;
        if (mis) begin
          e_redirect = i_res_taken ? i_res_target : h.pc + 32'd4;
          e_mcnt     = (e_mcnt >= MAXC) ? MAXC : e_mcnt + 1;
        end
      end
      e_mis = mis;
      if (mis) m_q.delete();
      else if (do_push) begin
        n.pc = i_pred_pc; n.taken = i_pred_taken; n.tgt = i_pred_target;
        m_q.push_back(n);
      end
    end
    @(posedge i_clk);
    #1;
    primed = 1;
    chk("upd_valid",   {31'b0, o_upd_valid},  {31'b0, e_upd_valid});
    chk("mispredict",  {31'b0, o_mispredict}, {31'b0, e_mis});
    chk("upd_pc",      o_upd_pc, e_upd_pc);
    chk("upd_taken",   {31'b0, o_upd_taken}, {31'b0, e_upd_taken});
    chk("redirect_pc", o_redirect_pc, e_redirect);
    chk("count",       32'(o_count), 32'(m_q.size()));
    chk("branch_cnt",  32'(o_branch_cnt), 32'(e_bcnt));
    chk("mispred_cnt", 32'(o_mispred_cnt), 32'(e_mcnt));
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300; pcs[3] = 32'h400;

    // Reset
    idle(); i_rst = 1; step();
    chk("rst_pred_ready", {31'b0, o_pred_ready}, 32'd1);
    chk("rst_res_ready",  {31'b0, o_res_ready},  32'd0);
    i_rst = 0;
    step();

    // Correctly predicted taken branch
    drive(1, 32'h100, 1, 32'h200, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 1, 32'h200); step();
    chk("d036_upd_pc", o_upd_pc, 32'h100);
    chk("d036_bcnt", 32'(o_branch_cnt), 32'd1);
    idle(); step();

    // Predicted not-taken, actually taken
    drive(1, 32'h100, 0, 32'h0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 1, 32'h300); step();
    chk("d037_mis", {31'b0, o_mispredict}, 32'd1);
    chk("d037_redirect", o_redirect_pc, 32'h300);
    idle(); step();

    // Three queued, first mispredicts not-taken, same-cycle push discarded
    for (int i = 0; i < 3; i++) begin
      drive(1, pcs[i], 1, pcs[i] + 32'h1000, 0, 0, 0); step();
    end
    drive(1, 32'h900, 1, 32'h990, 1, 0, 32'h0); step();
    chk("d038_redirect", o_redirect_pc, 32'h104);
    chk("d038_count", 32'(o_count), 32'd0);
    idle(); step();

    // Fill, overflow drop, push+resolve at count 3, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, pcs[i], 1, pcs[i] + 32'h40, 0, 0, 0); step();
    end
    chk("d039_full_ready", {31'b0, o_pred_ready}, 32'd0);
    drive(1, 32'h500, 1, 32'h540, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 1, 32'h140); step();
    drive(1, 32'h600, 0, 32'h0, 1, 1, 32'h240); step();
    chk("d039_count3", 32'(o_count), 32'd3);
    drive(0, 0, 0, 0, 1, 1, 32'h340); step();
    drive(0, 0, 0, 0, 1, 1, 32'h440); step();
    drive(0, 0, 0, 0, 1, 0, 32'h0); step();
    chk("d039_order_last", o_upd_pc, 32'h600);
    idle(); step();

    // Reset with two queued and a resolve active
    drive(1, 32'h700, 1, 32'h740, 0, 0, 0); step();
    drive(1, 32'h800, 1, 32'h840, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 1, 32'h740); i_rst = 1; step();
    chk("d040_upd_valid", {31'b0, o_upd_valid}, 32'd0);
    i_rst = 0; idle(); step();

    // Saturate mispredict counter
    for (int i = 0; i < MAXC + 3; i++) begin
      drive(1, 32'h1000 + 32'(i * 4), 0, 32'h0, 0, 0, 0); step();
      drive(0, 0, 0, 0, 1, 1, 32'h2000); step();
    end
    chk("d041_sat", 32'(o_mispred_cnt), 32'(MAXC));
    idle(); step();
    i_rst = 1; step(); i_rst = 0;

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ppc, ptg, rtg;
      logic pt, rt;
      ppc = 32'($urandom_range(0, 255)) << 2;
      ptg = 32'($urandom_range(0, 7)) << 4;
      pt  = 1'($urandom_range(0, 1));
      rt  = 1'($urandom_range(0, 1));
      rtg = 32'($urandom_range(0, 7)) << 4;
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = m_q[0].taken;
        rtg = m_q[0].tgt;
      end
      drive(1'($urandom_range(0, 99) < 60), ppc, pt, ptg,
            1'($urandom_range(0, 99) < 45), rt, rtg);
      i_rst = ($urandom_range(0, 63) == 0);
      step();
    end
    i_rst = 0; idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
- REQ-001: Parameter DEPTH, default 4, SHALL set the in-flight prediction queue depth (power of two, 2..16).
- REQ-002: Parameter PC_W, default 32, SHALL set the PC and target width.
- REQ-003: Parameter CNT_W, default 16, SHALL set the statistics counter width.
- REQ-004: i_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: i_rst  in  1  SHALL be a synchronous, active-high reset.
- REQ-006: i_pred_valid  in  1  SHALL indicate that fetch is recording a prediction this cycle.
- REQ-007: i_pred_pc  in  PC_W  SHALL be the PC of the predicted branch.
- REQ-008: i_pred_taken  in  1  SHALL be the predicted direction (1 = taken).
- REQ-009: i_pred_target  in  PC_W  SHALL be the predicted target.
- REQ-010: o_pred_ready  out  1  SHALL be high when the queue is not full.
- REQ-011: i_res_valid  in  1  SHALL indicate that execute resolves the oldest branch this cycle.
- REQ-012: i_res_taken  in  1  SHALL be the actual outcome.
- REQ-013: i_res_target  in  PC_W  SHALL be the actual target.
- REQ-014: o_res_ready  out  1  SHALL be high when the queue is not empty.
- REQ-015: o_upd_valid / o_upd_pc (PC_W) / o_upd_taken  out  SHALL carry the predictor training update.
- REQ-016: o_mispredict  out  1  SHALL be the one-cycle mispredict / flush pulse.
- REQ-017: o_redirect_pc  out  PC_W  SHALL be the corrected fetch PC, valid while o_mispredict is high.
- REQ-018: o_count  out  $clog2(DEPTH)+1  SHALL be the queue occupancy.
- REQ-019: o_branch_cnt / o_mispred_cnt  out  CNT_W  SHALL count resolved branches and mispredicts.

Function
- REQ-020: A push SHALL occur when i_pred_valid && o_pred_ready, storing {pc, taken, target} at the tail.
- REQ-021: i_pred_valid while full SHALL be dropped, with no state change.
- REQ-022: A resolve SHALL occur when i_res_valid && o_res_ready, comparing against and popping the head entry.
- REQ-023: i_res_valid while empty SHALL be ignored, with no outputs asserted.
- REQ-024: Mispredict SHALL be (i_res_taken != head.taken) || (i_res_taken && i_res_target != head.target).
- REQ-025: Redirect PC SHALL be i_res_target if i_res_taken, else head.pc + 4 (modulo 2^PC_W, wrap ignored).
- REQ-026: All outputs except o_pred_ready, o_res_ready and o_count SHALL be registered, with one-cycle latency after the resolve edge.
- REQ-027: Every resolve SHALL pulse o_upd_valid for one cycle, with o_upd_pc = head.pc and o_upd_taken = i_res_taken.
- REQ-028: On mispredict, the queue SHALL be flushed at the resolve edge (count → 0, pointers reset), because all younger entries are wrong-path.
- REQ-029: A push in the same cycle as a flushing resolve SHALL be discarded.
- REQ-030: A simultaneous push and non-mispredicting resolve SHALL leave the count unchanged; entry order is preserved.
- REQ-031: Pointers SHALL wrap modulo DEPTH; o_count SHALL distinguish full (DEPTH) from empty (0).
- REQ-032: o_branch_cnt SHALL increment per resolve, and o_mispred_cnt per mispredict; both saturate at 2^CNT_W-1.
- REQ-033: Back-to-back resolves SHALL be supported, one per cycle.

Reset
- REQ-034: When i_rst is high at a clock edge, the next-cycle outputs SHALL be: queue empty, o_count=0, o_pred_ready=1, o_res_ready=0, o_mispredict=0, o_upd_valid=0, o_redirect_pc=0, o_upd_pc=0, o_upd_taken=0, both counters 0.
- REQ-035: Reset SHALL take priority over any push or resolve in the same cycle; an in-flight resolve is lost with no update pulse.

Verification
- REQ-036: Push pc=0x100, taken=1, target=0x200; resolve taken=1, target=0x200 -> next cycle o_upd_valid=1, o_upd_pc=0x100, o_mispredict=0, o_branch_cnt=1.
- REQ-037: Push pc=0x100, taken=0; resolve taken=1, target=0x300 -> o_mispredict=1, o_redirect_pc=0x300, o_mispred_cnt=1.
- REQ-038: Push 3 entries; first resolves not-taken vs predicted taken -> o_redirect_pc=0x104, o_count=0 next cycle, and a same-cycle push is discarded.
- REQ-039: Push DEPTH entries -> o_pred_ready=0 and a 5th push is dropped; push+resolve at count 3 keeps count 3 and preserves FIFO order.
- REQ-040: Assert i_rst with 2 entries queued and a resolve active -> next cycle all outputs at reset values, with no o_upd_valid pulse.
- REQ-041: Force 2^CNT_W+2 mispredicts (CNT_W=4 build) -> o_mispred_cnt holds at 15.
